// File: rtl/rounder_pipe_if.sv
// Beat-level bus for rounder_pipe: input handshake, per-beat controls, output handshake and counter.
interface rounder_pipe_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 32,
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*IN_W-1:0]   in_data;
  logic [1:0]              mode;
  logic                    sat_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*W-1:0]      out_data;
  logic [LANES-1:0]        out_sat;
  logic [CNT_W-1:0]        sat_cnt;
  logic                    sat_clr;

  modport master (
    output in_valid, in_data, mode, sat_en, out_ready, sat_clr,
    input  in_ready, out_valid, out_data, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_data, mode, sat_en, out_ready, sat_clr,
    output in_ready, out_valid, out_data, out_sat, sat_cnt
  );
endinterface

// File: rtl/rounder_pipe.sv
// Multi-lane 2-stage rounder/saturator: Q(2I).(2F) products reduced to Q(I).(F) words,
// with per-beat rounding mode, optional clamping and a sticky saturation-event counter.
module rounder_pipe #(
  parameter int unsigned para_int_bits  = 7,
  parameter int unsigned para_frac_bits = 9,
  parameter int unsigned LANES          = 4,
  parameter int unsigned CNT_W          = 16
) (
  input logic           clk,
  input logic           rst,
  rounder_pipe_if.slave bus
);
  localparam int unsigned W     = para_int_bits + para_frac_bits;
  localparam int unsigned IN_W  = 2 * W;
  localparam int unsigned F     = para_frac_bits;
  localparam int unsigned KW    = IN_W - F;
  localparam int unsigned RND_W = KW + 1;
  localparam int unsigned HI_W  = RND_W - W + 1;
  localparam int unsigned PC_W  = $clog2(LANES + 1);

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sat_en_q, s1_sat_en_d;
  logic [RND_W-1:0]     s1_rnd_q [LANES];
  logic [RND_W-1:0]     s1_rnd_d [LANES];
  logic                 s2_valid_q, s2_valid_d;
  logic [LANES*W-1:0]   s2_data_q, s2_data_d;
  logic [LANES-1:0]     s2_sat_q, s2_sat_d;
  logic [CNT_W-1:0]     sat_cnt_q, sat_cnt_d;

  logic                 s1_adv_c, s2_adv_c;
  logic [IN_W-1:0]      x;
  logic [KW-1:0]        kv;
  logic                 rbit, sbit, inc;
  logic [RND_W-1:0]     rnd;
  logic [HI_W-1:0]      hi;
  logic                 ovf;
  logic [PC_W-1:0]      pc;
  logic [CNT_W:0]       cnt_sum;

  // Backpressure: a stage advances when it is empty or its successor advances.
  always_comb begin
    s2_adv_c = !s2_valid_q || bus.out_ready;
    s1_adv_c = !s1_valid_q || s2_adv_c;
  end

  // Stage 1: per-lane rounding to an integer that cannot overflow RND_W bits.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sat_en_d = s1_sat_en_q;
    s1_rnd_d    = s1_rnd_q;
    x    = '0;
    kv   = '0;
    rbit = 1'b0;
    sbit = 1'b0;
    inc  = 1'b0;
    if (s1_adv_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sat_en_d = bus.sat_en;
        for (int l = 0; l < LANES; l++) begin
          x    = bus.in_data[l*IN_W +: IN_W];
          kv   = x[IN_W-1:F];
          rbit = x[F-1];
          sbit = |x[F-2:0];
          case (bus.mode)
            2'd0:    inc = 1'b0;
            2'd2:    inc = rbit & (sbit | kv[0]);
            default: inc = rbit;
          endcase
          s1_rnd_d[l] = {kv[KW-1], kv} + RND_W'(inc);
        end
      end
    end
  end

  // Stage 2: range check, then clamp or wrap to W bits.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    rnd = '0;
    hi  = '0;
    ovf = 1'b0;
    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int l = 0; l < LANES; l++) begin
          rnd = s1_rnd_q[l];
          hi  = rnd[RND_W-1:W-1];
          ovf = !((&hi) || (~|hi));
          s2_sat_d[l] = ovf;
          if (ovf && s1_sat_en_q)
            s2_data_d[l*W +: W] = rnd[RND_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          else
            s2_data_d[l*W +: W] = rnd[W-1:0];
        end
      end
    end
  end

  // Saturation-event counter; a clear overrides any concurrent transfer.
  always_comb begin
    pc = '0;
    for (int l = 0; l < LANES; l++) pc = pc + PC_W'(s2_sat_q[l]);
    cnt_sum   = {1'b0, sat_cnt_q} + (CNT_W+1)'(pc);
    sat_cnt_d = sat_cnt_q;
    if (bus.sat_clr)
      sat_cnt_d = '0;
    else if (s2_valid_q && bus.out_ready)
      sat_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sat_en_q <= 1'b0;
      s1_rnd_q    <= '{default: '0};
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sat_q    <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sat_en_q <= s1_sat_en_d;
      s1_rnd_q    <= s1_rnd_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sat_q    <= s2_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_sat   = s2_sat_q;
  assign bus.sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_rounder_pipe.sv
// Directed bench for rounder_pipe: rounding modes, saturation/wrap, stall, reset and counter.
module tb_rounder_pipe;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_cnt;
  int   sent;
  int   rcv;
  logic xo, xi;
  logic [15:0] vo;

  rounder_pipe_if #(.LANES(4), .IN_W(32), .W(16), .CNT_W(16)) bus ();

  rounder_pipe #(
    .para_int_bits (7),
    .para_frac_bits(9),
    .LANES         (4),
    .CNT_W         (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One lane-0 beat through the pipe; other lanes carry zero.
  task automatic run_one(input string tag, input logic [31:0] x, input logic [1:0] md,
                         input logic se, input logic [15:0] exp_d, input logic exp_s);
    bus.in_data  = {96'b0, x};
    bus.mode     = md;
    bus.sat_en   = se;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk({tag, "_v"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_d"}, bus.out_data, {48'b0, exp_d});
    chk({tag, "_s"}, 64'(bus.out_sat), {60'b0, 3'b0, exp_s});
    step();
    exp_cnt += int'(exp_s);
    chk({tag, "_cnt"}, 64'(bus.sat_cnt), 64'(exp_cnt));
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = 2'd0;
    bus.sat_en    = 1'b0;
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_sat", 64'(bus.out_sat), 64'd0);
    chk("rst_cnt", 64'(bus.sat_cnt), 64'd0);
    rst = 1'b0;
    step();
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    // Saturate vs wrap of 33263.13
    run_one("t1_sat", 32'd17030722, 2'd0, 1'b1, 16'h7FFF, 1'b1);
    run_one("t2_wrap", 32'd17030722, 2'd0, 1'b0, 16'h81EF, 1'b1);

    // Rounding modes on +1.5, +2.5, -1.5
    run_one("r15_fl", 32'h0000_0300, 2'd0, 1'b1, 16'h0001, 1'b0);
    run_one("r15_hu", 32'h0000_0300, 2'd1, 1'b1, 16'h0002, 1'b0);
    run_one("r15_he", 32'h0000_0300, 2'd2, 1'b1, 16'h0002, 1'b0);
    run_one("r25_fl", 32'h0000_0500, 2'd0, 1'b1, 16'h0002, 1'b0);
    run_one("r25_hu", 32'h0000_0500, 2'd1, 1'b1, 16'h0003, 1'b0);
    run_one("r25_he", 32'h0000_0500, 2'd2, 1'b1, 16'h0002, 1'b0);
    run_one("r25_m3", 32'h0000_0500, 2'd3, 1'b1, 16'h0003, 1'b0);
    run_one("rn15_fl", 32'hFFFF_FD00, 2'd0, 1'b1, 16'hFFFE, 1'b0);
    run_one("rn15_hu", 32'hFFFF_FD00, 2'd1, 1'b1, 16'hFFFF, 1'b0);
    run_one("rn15_he", 32'hFFFF_FD00, 2'd2, 1'b1, 16'hFFFE, 1'b0);

    // Range edges: max exact, rounding past max, large negative clamp
    run_one("max_hu", 32'h00FF_FEFF, 2'd1, 1'b1, 16'h7FFF, 1'b0);
    run_one("max_fl", 32'h00FF_FF00, 2'd0, 1'b1, 16'h7FFF, 1'b0);
    run_one("ovr_hu", 32'h00FF_FF00, 2'd1, 1'b1, 16'h7FFF, 1'b1);
    run_one("ovr_he", 32'h00FF_FF00, 2'd2, 1'b0, 16'h8000, 1'b1);
    run_one("neg_sat", 32'h8000_0000, 2'd0, 1'b1, 16'h8000, 1'b1);

    // Independent lanes, clamped and wrapped
    bus.in_data  = {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FD00, 32'h0000_0300};
    bus.mode     = 2'd1;
    bus.sat_en   = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.sat_en   = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("lanes_sat_d", bus.out_data, {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0002});
    chk("lanes_sat_s", 64'(bus.out_sat), 64'hC);
    step();
    chk("lanes_wrap_d", bus.out_data, {16'h0000, 16'h0000, 16'hFFFF, 16'h0002});
    chk("lanes_wrap_s", 64'(bus.out_sat), 64'hC);
    step();
    exp_cnt += 4;
    chk("lanes_cnt", 64'(bus.sat_cnt), 64'(exp_cnt));

    // Stall with out_ready low: two beats held, input blocked, output stable
    bus.mode      = 2'd0;
    bus.sat_en    = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {96'b0, 32'h0000_0200};
    step();
    bus.in_data   = {96'b0, 32'h0000_0400};
    step();
    bus.in_data   = {96'b0, 32'h0000_0600};
    bus.mode      = 2'd1;
    bus.sat_en    = 1'b0;
    #1;
    chk("stall_ready0", 64'(bus.in_ready), 64'd0);
    chk("stall_valid0", 64'(bus.out_valid), 64'd1);
    chk("stall_data0", 64'(bus.out_data[15:0]), 64'h1);
    step();
    chk("stall_ready1", 64'(bus.in_ready), 64'd0);
    chk("stall_data1", 64'(bus.out_data[15:0]), 64'h1);
    step();
    chk("stall_valid2", 64'(bus.out_valid), 64'd1);
    chk("stall_data2", 64'(bus.out_data[15:0]), 64'h1);
    bus.mode      = 2'd0;
    bus.sat_en    = 1'b1;
    bus.out_ready = 1'b1;
    sent = 2;
    rcv  = 0;
    for (int cyc = 0; cyc < 20 && rcv < 4; cyc++) begin
      #1;
      xo = bus.out_valid & bus.out_ready;
      vo = bus.out_data[15:0];
      xi = bus.in_valid & bus.in_ready;
      step();
      if (xo) begin
        chk("stream_order", 64'(vo), 64'(rcv + 1));
        rcv++;
      end
      if (xi) begin
        sent++;
        if (sent < 4) bus.in_data = {96'b0, 32'((sent + 1) << 9)};
        else bus.in_valid = 1'b0;
      end
    end
    chk("stream_count", 64'(rcv), 64'd4);
    step();
    chk("stream_drained", 64'(bus.out_valid), 64'd0);

    // Reset with both stages full
    bus.out_ready = 1'b0;
    bus.in_data   = {96'b0, 32'h7FFF_FFFF};
    bus.in_valid  = 1'b1;
    step();
    step();
    bus.in_valid  = 1'b0;
    chk("mid_full", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(bus.sat_cnt), 64'd0);
    chk("mid_rst_data", bus.out_data, 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    exp_cnt = 0;
    repeat (3) step();
    chk("mid_no_stale", 64'(bus.out_valid), 64'd0);

    // Counter: 10 all-lane saturating beats, then enough to pin at all-ones
    bus.in_data  = {4{32'h7FFF_FFFF}};
    bus.sat_en   = 1'b1;
    bus.in_valid = 1'b1;
    step();
    step();
    chk("cnt_data", bus.out_data, {4{16'h7FFF}});
    chk("cnt_sat", 64'(bus.out_sat), 64'hF);
    repeat (8) step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("cnt_40", 64'(bus.sat_cnt), 64'd40);
    bus.in_valid = 1'b1;
    repeat (16375) step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("cnt_stick", 64'(bus.sat_cnt), 64'hFFFF);

    // Clear concurrent with a flagged transfer wins
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("clr_pre_valid", 64'(bus.out_valid), 64'd1);
    bus.sat_clr = 1'b1;
    step();
    bus.sat_clr = 1'b0;
    chk("clr_wins", 64'(bus.sat_cnt), 64'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("clr_recount", 64'(bus.sat_cnt), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
